// File: rtl/udma_cpi_pix_packer.sv
// udma_cpi_pix_packer
// Packs the 16-bit CPI pixel stream into 32-bit words for the uDMA RX channel.
// Modes: 00/11 pass-through 16-bit, 01 two 16-bit pixels per word,
// 10 four 8-bit pixels per word (in_data_i[7:0]). A frame_end_i pulse flushes
// any partial word, zero-padded, and then pulses flush_done_o.
//
// Ports:
//   clk_i, rstn_i       clock, synchronous active-low reset
//   cfg_en_i            stage enable (low clears accumulator, blocks input)
//   cfg_mode_i[1:0]     packing mode
//   frame_end_i         end-of-frame pulse, requests a flush
//   in_data_i[15:0], in_valid_i, in_ready_o     pixel stream in
//   out_data_o[31:0], out_datasize_o[1:0], out_valid_o, out_ready_i   word out
//   flush_done_o        one-cycle pulse when a frame-end flush is complete
//
// Optional feature: define CPI_PACK_BYTESWAP_EN to add cfg_swap_i, which
// byte-reverses every word as it is loaded into the output register.

module udma_cpi_pix_packer (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cfg_en_i,
    input  logic [1:0]  cfg_mode_i,
    input  logic        frame_end_i,
`ifdef CPI_PACK_BYTESWAP_EN
    input  logic        cfg_swap_i,
`endif
    input  logic [15:0] in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [31:0] out_data_o,
    output logic [1:0]  out_datasize_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        flush_done_o
);

    localparam int unsigned OUT_W = 32;
    localparam int unsigned IN_W  = 16;
    localparam logic [1:0]  DS_16 = 2'b01;
    localparam logic [1:0]  DS_32 = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state;
    logic [OUT_W-1:0] acc;
    logic [1:0]       cnt;

    logic             mode_pt;
    logic             mode8;
    logic             last_lane;
    logic             load_needed;
    logic             out_free;
    logic             accept;
    logic [1:0]       cnt_after;
    logic [OUT_W-1:0] word_in;
    logic [OUT_W-1:0] pt_word;
    logic [OUT_W-1:0] pk_word;
    logic [OUT_W-1:0] pad_word;

    // Mode decode; 11 behaves as pass-through
    assign mode_pt     = (cfg_mode_i == 2'b00) || (cfg_mode_i == 2'b11);
    assign mode8       = (cfg_mode_i == 2'b10);
    assign last_lane   = mode8 ? (cnt == 2'd3) : (cnt == 2'd1);
    assign load_needed = mode_pt || last_lane;

    // Output register can take a new word if empty or draining this cycle
    assign out_free    = !out_valid_o || out_ready_i;
    assign in_ready_o  = cfg_en_i && (state == ACCUM) && !(load_needed && !out_free);
    assign accept      = in_valid_i && in_ready_o;

    // Lane count once this cycle's pixel is counted; drives the flush decision
    assign cnt_after   = (accept && !mode_pt) ? (last_lane ? 2'd0 : 2'(cnt + 2'd1)) : cnt;

    // Accumulator with the incoming pixel merged into its lane
    always_comb begin
        word_in = acc;
        if (mode8) begin
            case (cnt)
                2'd0:    word_in[7:0]   = in_data_i[7:0];
                2'd1:    word_in[15:8]  = in_data_i[7:0];
                2'd2:    word_in[23:16] = in_data_i[7:0];
                default: word_in[31:24] = in_data_i[7:0];
            endcase
        end else if (cnt[0]) begin
            word_in[31:16] = in_data_i;
        end else begin
            word_in[15:0] = in_data_i;
        end
    end

`ifdef CPI_PACK_BYTESWAP_EN
    // Pass-through swaps only the low halfword; packed words reverse all bytes
    function automatic logic [OUT_W-1:0] swap_word(input logic [OUT_W-1:0] w, input logic pt);
        if (pt)
            swap_word = {w[31:16], w[7:0], w[15:8]};
        else
            swap_word = {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign pt_word  = cfg_swap_i ? swap_word({16'h0, in_data_i}, 1'b1) : {16'h0, in_data_i};
    assign pk_word  = cfg_swap_i ? swap_word(word_in, 1'b0) : word_in;
    assign pad_word = cfg_swap_i ? swap_word(acc, 1'b0) : acc;
`else
    assign pt_word  = {(OUT_W-IN_W)'(0), in_data_i};
    assign pk_word  = word_in;
    assign pad_word = acc;
`endif

    // Control FSM, accumulator and output register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state          <= IDLE;
            acc            <= '0;
            cnt            <= 2'd0;
            out_data_o     <= '0;
            out_datasize_o <= DS_32;
            out_valid_o    <= 1'b0;
            flush_done_o   <= 1'b0;
        end else begin
            flush_done_o <= 1'b0;
            // Drain; any load below takes priority
            if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    acc <= '0;
                    cnt <= 2'd0;
                    if (cfg_en_i) begin
                        state <= ACCUM;
                    end
                end

                ACCUM: begin
                    if (!cfg_en_i) begin
                        state <= IDLE;
                        acc   <= '0;
                        cnt   <= 2'd0;
                    end else begin
                        if (accept) begin
                            if (mode_pt) begin
                                out_data_o     <= pt_word;
                                out_datasize_o <= DS_16;
                                out_valid_o    <= 1'b1;
                            end else if (last_lane) begin
                                out_data_o     <= pk_word;
                                out_datasize_o <= DS_32;
                                out_valid_o    <= 1'b1;
                                acc            <= '0;
                                cnt            <= 2'd0;
                            end else begin
                                acc <= word_in;
                                cnt <= 2'(cnt + 2'd1);
                            end
                        end
                        if (frame_end_i) begin
                            if (cnt_after == 2'd0) begin
                                flush_done_o <= 1'b1;
                            end else begin
                                state <= FLUSH;
                            end
                        end
                    end
                end

                FLUSH: begin
                    if (!cfg_en_i) begin
                        state <= IDLE;
                        acc   <= '0;
                        cnt   <= 2'd0;
                    end else if (out_free) begin
                        // Unused lanes of acc are already zero
                        out_data_o     <= pad_word;
                        out_datasize_o <= DS_32;
                        out_valid_o    <= 1'b1;
                        acc            <= '0;
                        cnt            <= 2'd0;
                        flush_done_o   <= 1'b1;
                        state          <= ACCUM;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udma_cpi_pix_packer.sv
// Self-checking bench for udma_cpi_pix_packer: expected words are queued as
// stimulus is driven and compared as the output handshake completes.

module tb_udma_cpi_pix_packer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_en;
    logic [1:0]  cfg_mode;
    logic        frame_end;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_datasize;
    logic        out_valid;
    logic        out_ready;
    logic        flush_done;
`ifdef CPI_PACK_BYTESWAP_EN
    logic        cfg_swap = 1'b0;
`endif

    always #5 clk = ~clk;

    udma_cpi_pix_packer dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .cfg_en_i       (cfg_en),
        .cfg_mode_i     (cfg_mode),
        .frame_end_i    (frame_end),
`ifdef CPI_PACK_BYTESWAP_EN
        .cfg_swap_i     (cfg_swap),
`endif
        .in_data_i      (in_data),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .out_data_o     (out_data),
        .out_datasize_o (out_datasize),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .flush_done_o   (flush_done)
    );

    int          total = 0;
    int          bad   = 0;
    int          fd_cnt = 0;
    logic [33:0] exp_q[$];
    logic        bp_on = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: compare each accepted word against the scoreboard
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 64'(exp_q.size()), 64'd1);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                check("word", 64'({out_datasize, out_data}), 64'(e));
            end
        end
        if (flush_done) fd_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic fe);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
        frame_end = fe;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        cfg_en = 1'b0;
        tick();
        tick();
        cfg_mode = m;
        cfg_en   = 1'b1;
        tick();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_data"},  64'(out_data), 64'd0);
        check({tag, "_ds"},    64'(out_datasize), 64'd2);
        check({tag, "_fd"},    64'(flush_done), 64'd0);
        check({tag, "_rdy"},   64'(in_ready), 64'd0);
    endtask

    // Random back-pressure on the output
    initial begin
        wait (bp_on);
        while (bp_on) begin
            @(posedge clk);
            #1;
            if (bp_on) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        int          f0;
        rstn      = 1'b0;
        cfg_en    = 1'b0;
        cfg_mode  = 2'b00;
        frame_end = 1'b0;
        in_data   = 16'h0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check_reset_vals("rst");
        rstn = 1'b1;

        // Mode 01: two halfwords per word, valid one cycle after completing accept
        set_mode(2'b01);
        exp_q.push_back({2'b10, 32'h2222_1111});
        send(16'h1111, 1'b0);
        check("m01_no_early", 64'(out_valid), 64'd0);
        send(16'h2222, 1'b0);
        check("m01_latency", 64'(out_valid), 64'd1);
        wait_drain();

        // Mode 10: bytes, upper input bits ignored
        set_mode(2'b10);
        exp_q.push_back({2'b10, 32'hD4C3_B2A1});
        send(16'hFFA1, 1'b0);
        send(16'hFFB2, 1'b0);
        send(16'hFFC3, 1'b0);
        send(16'hFFD4, 1'b0);
        check("m10_latency", 64'(out_valid), 64'd1);
        wait_drain();

        // Pass-through, modes 00 and 11
        set_mode(2'b00);
        exp_q.push_back({2'b01, 32'h0000_1234});
        send(16'h1234, 1'b0);
        check("pt_latency", 64'(out_valid), 64'd1);
        set_mode(2'b11);
        exp_q.push_back({2'b01, 32'h0000_BEEF});
        send(16'hBEEF, 1'b0);
        wait_drain();

        // Back-pressure in mode 01
        set_mode(2'b01);
        exp_q.push_back({2'b10, 32'h2222_1111});
        exp_q.push_back({2'b10, 32'h4444_3333});
        out_ready = 1'b0;
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        in_data  = 16'h3333;
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_ready_partial", 64'(in_ready), 64'd1);
        tick();
        in_data = 16'h4444;
        @(negedge clk);
        check("bp_ready_low", 64'(in_ready), 64'd0);
        check("bp_hold_data", 64'(out_data), 64'h2222_1111);
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        tick();
        check("bp_hold_data2", 64'(out_data), 64'h2222_1111);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_resume", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        wait_drain();

        // Flush of a partial byte word
        set_mode(2'b10);
        exp_q.push_back({2'b10, 32'h0003_0201});
        f0 = fd_cnt;
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b0);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        @(negedge clk);
        check("flush_ready_low", 64'(in_ready), 64'd0);
        tick();
        check("flush_done", 64'(flush_done), 64'd1);
        check("flush_valid", 64'(out_valid), 64'd1);
        check("flush_data", 64'(out_data), 64'h0003_0201);
        wait_drain();
        check("flush_fd_count", 64'(fd_cnt), 64'(f0 + 1));

        // Frame end with nothing to pad
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("fe_empty_done", 64'(flush_done), 64'd1);
        check("fe_empty_noword", 64'(out_valid), 64'd0);
        tick();
        check("fe_pulse_once", 64'(flush_done), 64'd0);

        // Frame end coincident with the completing pixel
        set_mode(2'b01);
        exp_q.push_back({2'b10, 32'hBBBB_AAAA});
        f0 = fd_cnt;
        send(16'hAAAA, 1'b0);
        send(16'hBBBB, 1'b1);
        check("sim_valid", 64'(out_valid), 64'd1);
        check("sim_done", 64'(flush_done), 64'd1);
        repeat (4) tick();
        check("sim_queue", 64'(exp_q.size()), 64'd0);
        check("sim_fd_count", 64'(fd_cnt), 64'(f0 + 1));

        // Disable mid-word discards the partial pixel
        exp_q.push_back({2'b10, 32'h7777_6666});
        send(16'h5555, 1'b0);
        cfg_en = 1'b0;
        tick();
        tick();
        check("dis_noword", 64'(out_valid), 64'd0);
        check("dis_ready", 64'(in_ready), 64'd0);
        cfg_en = 1'b1;
        tick();
        send(16'h6666, 1'b0);
        send(16'h7777, 1'b0);
        wait_drain();

        // Random bytes under random back-pressure
        set_mode(2'b10);
        w = 32'h0;
        bp_on = 1'b1;
        for (int i = 0; i < 24; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            w[8*(i%4) +: 8] = b;
            if ((i % 4) == 3) begin
                exp_q.push_back({2'b10, w});
                w = 32'h0;
            end
            send({8'($urandom), b}, 1'b0);
        end
        bp_on = 1'b0;
        tick();
        tick();
        out_ready = 1'b1;
        wait_drain();

        // Synchronous reset mid-stream with a stalled word
        set_mode(2'b01);
        out_ready = 1'b0;
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b0);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        rstn = 1'b0;
        tick();
        check_reset_vals("mid_rst");
        rstn      = 1'b1;
        out_ready = 1'b1;
        tick();
        exp_q.push_back({2'b10, 32'hAAAA_9999});
        send(16'h9999, 1'b0);
        send(16'hAAAA, 1'b0);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udma_cpi_pix_packer.md
# udma_cpi_pix_packer

Pixel packing stage between the CPI camera interface's RX data output (16-bit pixel stream, valid/ready) and the uDMA linear RX channel. It packs 8-bit or 16-bit pixels into full 32-bit words, drives the channel's datasize field, and pads out and flushes any partial word at frame end. This lets the uDMA move one 32-bit word per L2 write instead of one pixel per write.

## Interface
- No parameters; input width 16, output width 32, fixed.
- `clk_i`  in  1  peripheral clock; single clock domain.
- `rstn_i`  in  1  reset, synchronous, active-low.
- `cfg_en_i`  in  1  stage enable. Low: accumulator cleared, no input accepted.
- `cfg_mode_i`  in  2  packing mode:
  - 00: pass-through 16-bit.
  - 01: 2×16→32.
  - 10: 4×8→32, using `in_data_i[7:0]`.
  - 11: treated as 00.
- `frame_end_i`  in  1  one-cycle pulse at end of frame (vsync edge); requests a flush.
- `in_data_i`  in  16  pixel from the camera interface.
- `in_valid_i`  in  1  pixel valid.
- `in_ready_o`  out  1  pixel accepted when high together with `in_valid_i`.
- `out_data_o`  out  32  word to the uDMA RX channel.
- `out_datasize_o`  out  2  01 = 16-bit (pass-through), 10 = 32-bit (packed modes).
- `out_valid_o`  out  1  word valid.
- `out_ready_i`  in  1  channel ready.
- `flush_done_o`  out  1  one-cycle pulse when the frame-end flush has completed.

## Operation
- **Datapath:** accumulator `acc[31:0]`, lane counter `cnt[1:0]`, one output register (`out_data_o`, `out_valid_o`).
- **Packing order:** little-endian. The first accepted pixel occupies the lowest lane.
  - Mode 01: lanes [15:0], [31:16].
  - Mode 10: byte lanes 0..3.
- **Word complete:** when the accepting pixel fills the last lane (cnt==1 in mode 01, cnt==3 in mode 10):
  - the assembled word is loaded into the output register;
  - `cnt` returns to 0.
- **Pass-through (00/11):** each accepted pixel is loaded directly as `{16'h0, in_data_i}` with datasize 01.
- **Input ready:**
  - `in_ready_o = cfg_en_i && state==ACCUM && !(load_needed && out_valid_o && !out_ready_i)`.
  - `load_needed` is high when the current pixel would complete a word, or always in pass-through.
  - `in_ready_o` depends combinationally on `out_ready_i`. A load and a drain of the output register may happen in the same cycle.
- **States:**
  - **IDLE:** `cfg_en_i`=0. Go to ACCUM when `cfg_en_i` rises.
  - **ACCUM:** normal packing.
    - `frame_end_i` with `cnt`==0 after the current cycle's accept: pulse `flush_done_o` next cycle, stay in ACCUM.
    - `frame_end_i` with `cnt`≠0: go to FLUSH.
  - **FLUSH:** `in_ready_o`=0.
    - The partial word, with unused lanes zero and datasize 10, is loaded once the output register is free or draining.
    - Then `cnt` is set to 0, `flush_done_o` pulses, and the state returns to ACCUM.
    - Any `frame_end_i` received while in FLUSH is ignored.
- **Simultaneous `frame_end_i` and input accept:** the pixel is counted first, then the flush decision is made. If that pixel completes the word, no padding word is produced.
- **Mode change:** only legal while `cfg_en_i`=0. Otherwise the behaviour is undefined but must not deadlock.
- **`cfg_en_i` falling mid-word:** accumulator and `cnt` are cleared and the state goes to IDLE. A word already in the output register is still presented until it is accepted.

## Timing
- **Reset values:** `out_data_o`=0, `out_datasize_o`=2'b10, `out_valid_o`=0, `flush_done_o`=0, `in_ready_o`=0, state IDLE, `acc`=0, `cnt`=0.
- **Latency:** `out_valid_o` rises on the cycle after the accept that completes a word (all modes). In pass-through this is 1 cycle per pixel.
- **Throughput:** one pixel per cycle sustained while `out_ready_i`=1.
- **Output handshake:** `out_data_o`/`out_datasize_o` stay stable while `out_valid_o`=1 and `out_ready_i`=0.
- **Flush completion:** `flush_done_o` pulses on the cycle after the padded word is loaded, or the cycle after `frame_end_i` when there is nothing to pad.

## Configuration
- Macro `CPI_PACK_BYTESWAP_EN`.
- **Defined:**
  - adds input `cfg_swap_i` (1 bit);
  - when `cfg_swap_i`=1, the loaded word is byte-reversed: [31:24]↔[7:0], [23:16]↔[15:8] in packed modes, [15:8]↔[7:0] in pass-through;
  - the swap is applied at output-register load, and padding is swapped with the data.
- **Undefined:** port absent; no swap logic.

## Test plan
- **Mode 01 packing:** inputs 16'h1111, 16'h2222, out_ready_i=1 → one word 32'h2222_1111, datasize 10, `out_valid_o` one cycle after the second accept.
- **Mode 10 packing:** bytes 0xA1, 0xB2, 0xC3, 0xD4 → 32'hD4C3_B2A1. Upper input bits (e.g. 16'hFF00 | byte) are ignored.
- **Back-pressure:** mode 01 with out_ready_i=0 after first word loaded → `in_ready_o` stays 1 for the next pixel, drops to 0 on the pixel that would complete the second word. Output word unchanged; resumes with no loss when ready.
- **Flush:**
  - Mode 10, 3 bytes 01,02,03 then `frame_end_i` → word 32'h0003_0201, then `flush_done_o` pulse.
  - `frame_end_i` with cnt=0 → `flush_done_o` next cycle, no word.
- **Simultaneous event:** mode 01, second pixel accepted in the same cycle as `frame_end_i` → exactly one word, no padding word, `flush_done_o` pulse.
- **Disable and reset:** `cfg_en_i` dropped after one pixel in mode 01 → partial word discarded, no output.
  - Then `rstn_i`=0 for one edge mid-stream → all outputs at reset values on the next cycle.
